// File: rtl/wb_tgt_regfile_if.sv
// Pipelined Wishbone B4 target bus bundle for wb_tgt_regfile.
interface wb_tgt_regfile_if #(
   parameter int ADR_WIDTH = 4,
   parameter int DAT_WIDTH = 16,
   parameter int SEL_WIDTH = 2
);
   logic                 tgt_cyc_i;
   logic                 tgt_stb_i;
   logic                 tgt_we_i;
   logic [SEL_WIDTH-1:0] tgt_sel_i;
   logic [ADR_WIDTH-1:0] tgt_adr_i;
   logic [DAT_WIDTH-1:0] tgt_dat_i;
   logic                 tgt_ack_o;
   logic                 tgt_err_o;
   logic                 tgt_rty_o;
   logic                 tgt_stall_o;
   logic [DAT_WIDTH-1:0] tgt_dat_o;

   modport master (
      output tgt_cyc_i, tgt_stb_i, tgt_we_i, tgt_sel_i, tgt_adr_i, tgt_dat_i,
      input  tgt_ack_o, tgt_err_o, tgt_rty_o, tgt_stall_o, tgt_dat_o
   );

   modport slave (
      input  tgt_cyc_i, tgt_stb_i, tgt_we_i, tgt_sel_i, tgt_adr_i, tgt_dat_i,
      output tgt_ack_o, tgt_err_o, tgt_rty_o, tgt_stall_o, tgt_dat_o
   );
endinterface

// File: rtl/wb_tgt_regfile.sv
// Wishbone B4 pipelined register-file target with programmable wait states.
// Out-of-range addresses terminate with err; terminations are single-cycle
// and gated by cyc so an abandoned cycle never sees a stale ack/err.
module wb_tgt_regfile #(
   parameter int ADR_WIDTH   = 4,
   parameter int DAT_WIDTH   = 16,
   parameter int SEL_WIDTH   = 2,
   parameter int WORDS       = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic            clk_i,
   input  logic            async_rst_n_i,
   wb_tgt_regfile_if.slave tgt
);
   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   localparam logic [1:0]         WS      = 2'(WAIT_STATES);
   localparam logic [ADR_WIDTH:0] WORDS_L = (ADR_WIDTH+1)'(WORDS);

   state_t               state_q, state_d;
   logic [1:0]           cnt_q, cnt_d;
   logic                 req, stall, accept, adr_ok;
   logic                 ack_q, err_q;
   logic [DAT_WIDTH-1:0] dat_q;
   logic [DAT_WIDTH-1:0] mem [WORDS];

   assign req    = tgt.tgt_cyc_i & tgt.tgt_stb_i;
   assign accept = req & ~stall;
   assign adr_ok = {1'b0, tgt.tgt_adr_i} < WORDS_L;

   // Wait-counter state register
   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: count stalled request cycles, restart on accept or drop
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!req || accept) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = 2'd1;
               end
            end
            ST_WAIT: begin
               if (cnt_q < WS) cnt_d = cnt_q + 2'd1;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Stall until the request has waited the full WAIT_STATES cycles
   always_comb begin
      stall = req & (cnt_q != WS);
   end

   // Single-cycle termination and read-data capture at each acceptance
   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= accept & adr_ok;
         err_q <= accept & ~adr_ok;
         if (accept) dat_q <= (!tgt.tgt_we_i && adr_ok) ? mem[tgt.tgt_adr_i] : '0;
      end
   end

   // Register file with byte-lane write enables
   always_ff @(posedge clk_i or negedge async_rst_n_i) begin
      if (!async_rst_n_i) begin
         for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
      end else if (accept && tgt.tgt_we_i && adr_ok) begin
         for (int unsigned i = 0; i < SEL_WIDTH; i++)
            if (tgt.tgt_sel_i[i]) mem[tgt.tgt_adr_i][8*i +: 8] <= tgt.tgt_dat_i[8*i +: 8];
      end
   end

   assign tgt.tgt_stall_o = stall;
   assign tgt.tgt_ack_o   = ack_q & tgt.tgt_cyc_i;
   assign tgt.tgt_err_o   = err_q & tgt.tgt_cyc_i;
   assign tgt.tgt_rty_o   = 1'b0;
   assign tgt.tgt_dat_o   = dat_q;
endmodule

// File: doc/wb_tgt_regfile.md
WB_TGT_REGFILE -- requirements
Module: wb_tgt_regfile

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- ADR_WIDTH, 4, word address width
- DAT_WIDTH, 16, data bus width
- SEL_WIDTH, 2, byte selects; DAT_WIDTH = 8*SEL_WIDTH
- WORDS, 12, implemented registers, 1..2^ADR_WIDTH
- WAIT_STATES, 1, stall cycles inserted before each acceptance, 0..3
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i, in, 1, module clock
- async_rst_n_i, in, 1, reset, asynchronous, active-low
- tgt_cyc_i, in, 1, bus cycle indicator
- tgt_stb_i, in, 1, access request
- tgt_we_i, in, 1, write enable
- tgt_sel_i, in, SEL_WIDTH, byte lane selects
- tgt_adr_i, in, ADR_WIDTH, word address
- tgt_dat_i, in, DAT_WIDTH, write data
- tgt_ack_o, out, 1, normal termination
- tgt_err_o, out, 1, error termination
- tgt_rty_o, out, 1, retry, constant 0
- tgt_stall_o, out, 1, access delay
- tgt_dat_o, out, DAT_WIDTH, read data
REQ-003 The block SHALL be a pipelined Wishbone B4 target with a single clock, clk_i, and a single asynchronous active-low reset, async_rst_n_i.

Function
REQ-004 The block SHALL define req = tgt_cyc_i & tgt_stb_i and accept = req & ~tgt_stall_o.
REQ-005 The block SHALL run a wait counter FSM with states IDLE (cnt=0) and WAIT (cnt>0). IDLE goes to WAIT on req when WAIT_STATES>0. WAIT increments cnt on req while cnt<WAIT_STATES. Any acceptance or ~req returns the FSM to IDLE with cnt=0.
REQ-006 The block SHALL drive tgt_stall_o = req & (cnt != WAIT_STATES) combinationally. With WAIT_STATES=0, stall SHALL stay 0 and back-to-back acceptance SHALL occur every cycle.
REQ-007 Each accepted request at edge N SHALL produce exactly one single-cycle termination in cycle N+1: err if tgt_adr_i >= WORDS, otherwise ack.
REQ-008 The block SHALL never assert ack and err in the same cycle. tgt_rty_o SHALL be 0 at all times.
REQ-009 Terminations SHALL be gated combinationally with tgt_cyc_i. A termination due while tgt_cyc_i=0 SHALL be discarded, with no later replay.
REQ-010 An accepted write to a valid address SHALL update byte lane i of mem[adr] from tgt_dat_i when tgt_sel_i[i]=1, at the acceptance edge. Unselected lanes SHALL be unchanged.
REQ-011 An accepted read to a valid address SHALL register mem[adr] (full word, sel ignored) into tgt_dat_o. Every other acceptance (write or err) SHALL register 0. tgt_dat_o SHALL hold its value between acceptances.
REQ-012 Writes to addresses >= WORDS SHALL have no effect on any register.
REQ-013 A read accepted in the same cycle as a completed earlier write SHALL return the post-write value: the write edge precedes the read acceptance edge.
REQ-014 Dropping tgt_stb_i or tgt_cyc_i during stall SHALL clear cnt, so a renewed request waits the full WAIT_STATES.
REQ-015 The block SHALL keep at most one termination in flight, which bounds outstanding requests to 1 per cycle.

Reset
REQ-016 While async_rst_n_i=0, the block SHALL immediately force the FSM to IDLE, cnt=0, all registers to 0, and tgt_dat_o, the pending ack and the pending err to 0.
REQ-017 Reset mid-operation SHALL discard any pending termination and in-progress wait. The first edge after deassertion SHALL behave as IDLE.

Verification
REQ-018 The bench SHALL cover: WAIT_STATES=1, write adr=3 dat=0xBEEF sel=2'b11 -> stall=1 one cycle, ack one cycle after acceptance; then read adr=3 -> ack, tgt_dat_o=0xBEEF.
REQ-019 The bench SHALL cover: write adr=3 dat=0x1234 sel=2'b01 over 0xBEEF -> subsequent read returns 0xBE34.
REQ-020 The bench SHALL cover: read adr=12 (WORDS=12) -> err=1, ack=0, tgt_dat_o=0. Write adr=15 -> err, and all registers unchanged.
REQ-021 The bench SHALL cover: WAIT_STATES=0, four back-to-back reads adr=0..3 with stb held -> stall stays 0, ack high four consecutive cycles, data in order.
REQ-022 The bench SHALL cover: request accepted, then cyc_i dropped the next cycle -> no ack/err observed. Stb dropped mid-stall and reissued -> full WAIT_STATES stall again.
REQ-023 The bench SHALL cover: async_rst_n_i pulsed low between edges during a pending ack -> ack=0 immediately, all reads return 0 after reset.
